// File: rtl/ysyx_idu_issue_pkg.sv
// Shared decode constants for the IDU issue stage: RV32 major opcodes and the
// per-opcode source-register usage classification.
package ysyx_idu_issue_pkg;

  localparam logic [6:0] YSYX_OP_LUI    = 7'b0110111;
  localparam logic [6:0] YSYX_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] YSYX_OP_JAL    = 7'b1101111;
  localparam logic [6:0] YSYX_OP_JALR   = 7'b1100111;
  localparam logic [6:0] YSYX_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] YSYX_OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] YSYX_OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] YSYX_OP_OP     = 7'b0110011;
  localparam logic [6:0] YSYX_OP_STORE  = 7'b0100011;
  localparam logic [6:0] YSYX_OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    YSYX_SRC_NONE = 2'd0,
    YSYX_SRC_RS1  = 2'd1,
    YSYX_SRC_RS12 = 2'd2
  } ysyx_src_use_e;

  function automatic ysyx_src_use_e src_use(input logic [6:0] op);
    case (op)
      YSYX_OP_LUI, YSYX_OP_AUIPC, YSYX_OP_JAL:                      src_use = YSYX_SRC_NONE;
      YSYX_OP_JALR, YSYX_OP_LOAD, YSYX_OP_OP_IMM, YSYX_OP_SYSTEM:   src_use = YSYX_SRC_RS1;
      YSYX_OP_OP, YSYX_OP_STORE, YSYX_OP_BRANCH:                    src_use = YSYX_SRC_RS12;
      default:                                                      src_use = YSYX_SRC_NONE;
    endcase
  endfunction

  // Unrecognised opcodes never claim a destination.
  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      YSYX_OP_LUI, YSYX_OP_AUIPC, YSYX_OP_JAL, YSYX_OP_JALR,
      YSYX_OP_LOAD, YSYX_OP_OP_IMM, YSYX_OP_OP, YSYX_OP_SYSTEM:     writes_rd = 1'b1;
      default:                                                      writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_idu_issue_scoreboard.sv
// In-flight writer scoreboard: busy marks registers with an outstanding producer,
// spec_busy marks those whose producer was issued under an unresolved prediction.
module ysyx_idu_scoreboard #(
  parameter int NR_REG = 16,
  parameter int RIDX_W = $clog2(NR_REG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_valid,
  input  logic [RIDX_W-1:0] set_rd,
  input  logic              set_spec,
  input  logic              clr_valid,
  input  logic [RIDX_W-1:0] clr_rd,
  input  logic              spec_commit,
  input  logic              flush,
  output logic [NR_REG-1:0] busy,
  output logic [NR_REG-1:0] spec_busy
);

  localparam logic [NR_REG-1:0] ONE_HOT0 = {{(NR_REG-1){1'b0}}, 1'b1};
  localparam logic [NR_REG-1:0] ZERO_V   = {NR_REG{1'b0}};

  logic [NR_REG-1:0] busy_r, spec_r;
  logic [NR_REG-1:0] busy_nxt_s, spec_nxt_s;
  logic [NR_REG-1:0] set_mask_s, clr_mask_s, busy_cl_s, spec_cl_s;

  // Next-state: retirement clears first, then a newer issue sets (set wins);
  // a flush drops every speculative producer and wins over commit.
  always_comb begin
    set_mask_s = set_valid ? (ONE_HOT0 << set_rd) : ZERO_V;
    clr_mask_s = clr_valid ? (ONE_HOT0 << clr_rd) : ZERO_V;
    busy_cl_s  = busy_r & ~clr_mask_s;
    spec_cl_s  = spec_r & ~clr_mask_s;
    busy_nxt_s = busy_cl_s;
    spec_nxt_s = spec_cl_s;
    if (flush) begin
      busy_nxt_s = busy_cl_s & ~spec_cl_s;
      spec_nxt_s = ZERO_V;
    end else begin
      busy_nxt_s = busy_cl_s | set_mask_s;
      spec_nxt_s = (spec_commit ? ZERO_V : spec_cl_s) | (set_spec ? set_mask_s : ZERO_V);
    end
    busy_nxt_s = busy_nxt_s & ~ONE_HOT0;
    spec_nxt_s = spec_nxt_s & ~ONE_HOT0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= ZERO_V;
      spec_r <= ZERO_V;
    end else begin
      busy_r <= busy_nxt_s;
      spec_r <= spec_nxt_s;
    end
  end

  assign busy      = busy_r;
  assign spec_busy = spec_r;

endmodule

// File: rtl/ysyx_idu_issue.sv
// Decode/issue stage: one-entry holding register, multi-channel operand
// forwarding, RAW hazard detection against an internal scoreboard, and squash.
module ysyx_idu_issue
  import ysyx_idu_issue_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NR_REG = 16,
  parameter int FWD_N  = 2,
  parameter int RIDX_W = $clog2(NR_REG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_inst,
  input  logic [XLEN-1:0]         in_pc,
  input  logic                    in_spec,
  output logic [RIDX_W-1:0]       rf_raddr1,
  output logic [RIDX_W-1:0]       rf_raddr2,
  input  logic [XLEN-1:0]         rf_rdata1,
  input  logic [XLEN-1:0]         rf_rdata2,
  input  logic [FWD_N-1:0]        fwd_valid,
  input  logic [FWD_N*RIDX_W-1:0] fwd_rd,
  input  logic [FWD_N*XLEN-1:0]   fwd_data,
  input  logic                    wb_valid,
  input  logic [RIDX_W-1:0]       wb_rd,
  input  logic                    spec_commit,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_inst,
  output logic [XLEN-1:0]         out_pc,
  output logic                    out_spec,
  output logic [XLEN-1:0]         out_rs1v,
  output logic [XLEN-1:0]         out_rs2v,
  output logic [RIDX_W-1:0]       out_rd,
  output logic                    out_wen,
  output logic                    out_illegal,
  output logic                    hazard_o
);

  localparam logic [5:0] NR_REG_L = 6'(NR_REG);

  logic            valid_r, spec_r;
  logic [31:0]     inst_r;
  logic [XLEN-1:0] pc_r;

  logic [6:0]        op_s;
  logic [4:0]        rd_f_s, rs1_f_s, rs2_f_s;
  logic [RIDX_W-1:0] rd_idx_s, rs1_idx_s, rs2_idx_s;
  ysyx_src_use_e     src_use_s;
  logic              use1_s, use2_s, wr_s;
  logic              oor_rd_s, oor1_s, oor2_s, illegal_s, wen_s;
  logic [FWD_N-1:0]  hit1_s, hit2_s;
  logic [XLEN-1:0]   fwd1_s, fwd2_s;
  logic              blocked1_s, blocked2_s, hazard_s;
  logic              issue_s, accept_s, out_valid_s, in_ready_s;
  logic [NR_REG-1:0] busy_s, spec_busy_s;

  assign op_s      = inst_r[6:0];
  assign rd_f_s    = inst_r[11:7];
  assign rs1_f_s   = inst_r[19:15];
  assign rs2_f_s   = inst_r[24:20];
  assign rd_idx_s  = rd_f_s[RIDX_W-1:0];
  assign rs1_idx_s = rs1_f_s[RIDX_W-1:0];
  assign rs2_idx_s = rs2_f_s[RIDX_W-1:0];

  assign src_use_s = src_use(op_s);
  assign use1_s    = (src_use_s != YSYX_SRC_NONE);
  assign use2_s    = (src_use_s == YSYX_SRC_RS12);
  assign wr_s      = writes_rd(op_s);

  assign oor_rd_s  = ({1'b0, rd_f_s}  >= NR_REG_L);
  assign oor1_s    = ({1'b0, rs1_f_s} >= NR_REG_L);
  assign oor2_s    = ({1'b0, rs2_f_s} >= NR_REG_L);
  // Illegal instructions still flow to the EXU to trap, but never claim rd.
  assign illegal_s = (use1_s & oor1_s) | (use2_s & oor2_s) | (wr_s & oor_rd_s);
  assign wen_s     = wr_s & (rd_f_s != 5'd0) & ~illegal_s;

  for (genvar g = 0; g < FWD_N; g++) begin : g_fwd
    assign hit1_s[g] = fwd_valid[g] & (fwd_rd[g*RIDX_W +: RIDX_W] == rs1_idx_s);
    assign hit2_s[g] = fwd_valid[g] & (fwd_rd[g*RIDX_W +: RIDX_W] == rs2_idx_s);
  end

  // Priority pick of forwarded data: walking down means channel 0 wins.
  always_comb begin
    fwd1_s = {XLEN{1'b0}};
    fwd2_s = {XLEN{1'b0}};
    for (int i = FWD_N - 1; i >= 0; i--) begin
      fwd1_s = hit1_s[i] ? fwd_data[i*XLEN +: XLEN] : fwd1_s;
      fwd2_s = hit2_s[i] ? fwd_data[i*XLEN +: XLEN] : fwd2_s;
    end
  end

  assign out_rs1v = (rs1_f_s == 5'd0) ? {XLEN{1'b0}} : ((|hit1_s) ? fwd1_s : rf_rdata1);
  assign out_rs2v = (rs2_f_s == 5'd0) ? {XLEN{1'b0}} : ((|hit2_s) ? fwd2_s : rf_rdata2);

  // Out-of-range fields have no scoreboard entry and so never stall.
  assign blocked1_s = use1_s & (rs1_f_s != 5'd0) & ~oor1_s & busy_s[rs1_idx_s] & ~(|hit1_s);
  assign blocked2_s = use2_s & (rs2_f_s != 5'd0) & ~oor2_s & busy_s[rs2_idx_s] & ~(|hit2_s);
  assign hazard_s   = valid_r & (blocked1_s | blocked2_s);

  assign out_valid_s = valid_r & ~hazard_s & ~flush;
  assign in_ready_s  = ~valid_r | (out_ready & ~hazard_s & ~flush);
  assign issue_s     = out_valid_s & out_ready;
  assign accept_s    = in_valid & in_ready_s & ~flush;

  // Stage register: flush drops, accept loads, issue empties, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      inst_r  <= 32'd0;
      pc_r    <= {XLEN{1'b0}};
      spec_r  <= 1'b0;
    end else begin
      if (flush) begin
        valid_r <= 1'b0;
      end else if (accept_s) begin
        valid_r <= 1'b1;
      end else if (issue_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
      if (accept_s) begin
        inst_r <= in_inst;
        pc_r   <= in_pc;
        spec_r <= in_spec;
      end else begin
        inst_r <= inst_r;
        pc_r   <= pc_r;
        spec_r <= spec_r;
      end
    end
  end

  ysyx_idu_scoreboard #(
    .NR_REG (NR_REG),
    .RIDX_W (RIDX_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_valid   (issue_s & wen_s),
    .set_rd      (rd_idx_s),
    .set_spec    (spec_r),
    .clr_valid   (wb_valid),
    .clr_rd      (wb_rd),
    .spec_commit (spec_commit),
    .flush       (flush),
    .busy        (busy_s),
    .spec_busy   (spec_busy_s)
  );

  assign rf_raddr1   = rs1_idx_s;
  assign rf_raddr2   = rs2_idx_s;
  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_s;
  assign out_inst    = inst_r;
  assign out_pc      = pc_r;
  assign out_spec    = spec_r;
  assign out_rd      = rd_idx_s;
  assign out_wen     = wen_s;
  assign out_illegal = illegal_s;
  assign hazard_o    = hazard_s;

endmodule

// File: tb/tb_ysyx_idu_issue.sv
// Self-checking bench for ysyx_idu_issue: a cycle-level reference model checked
// on every falling edge, plus directed scenarios with literal expectations.
module tb_ysyx_idu_issue;

  localparam int NR = 16;
  localparam int RW = 4;
  localparam int FW = 2;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_spec;
  logic [31:0] in_inst, in_pc;
  logic [RW-1:0] rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [FW-1:0] fwd_valid;
  logic [FW*RW-1:0] fwd_rd;
  logic [FW*32-1:0] fwd_data;
  logic        wb_valid, spec_commit, flush, out_valid, out_ready, out_spec;
  logic [RW-1:0] wb_rd, out_rd;
  logic [31:0] out_inst, out_pc, out_rs1v, out_rs2v;
  logic        out_wen, out_illegal, hazard_o;

  logic [31:0] rf [NR];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  ysyx_idu_issue #(.XLEN(32), .NR_REG(NR), .FWD_N(FW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_spec(in_spec),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .spec_commit(spec_commit), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_spec(out_spec), .out_rs1v(out_rs1v), .out_rs2v(out_rs2v),
    .out_rd(out_rd), .out_wen(out_wen), .out_illegal(out_illegal), .hazard_o(hazard_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(int rd, int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(int rd, int rs1, int imm);
    return {12'(imm), 5'(rs1), 3'd0, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_u(int rd);
    return {20'd0, 5'(rd), 7'b0110111};
  endfunction
  function automatic logic [31:0] enc_s(int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'b0100011};
  endfunction

  // ---------------- reference model ----------------
  function automatic int n_src(logic [6:0] op);
    case (op)
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: return 1;
      7'b0110011, 7'b0100011, 7'b1100011:             return 2;
      default:                                        return 0;
    endcase
  endfunction
  function automatic bit has_rd(logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b0000011, 7'b0010011, 7'b0110011, 7'b1110011: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction
  function automatic int fwd_hit(int rs);
    for (int c = 0; c < FW; c++)
      if (fwd_valid[c] && int'(fwd_rd[c*RW +: RW]) == rs) return c;
    return -1;
  endfunction
  function automatic logic [31:0] opnd(int rs);
    int h;
    if (rs == 0) return 32'd0;
    h = fwd_hit(rs);
    if (h >= 0) return fwd_data[h*32 +: 32];
    return rf[rs];
  endfunction

  bit          m_valid = 1'b0;
  bit          m_spec  = 1'b0;
  logic [31:0] m_inst  = 32'd0;
  logic [31:0] m_pc    = 32'd0;
  logic [NR-1:0] m_busy  = '0;
  logic [NR-1:0] m_sbusy = '0;

  always @(negedge clk) begin : cmp
    int rd, rs1, rs2, ns;
    bit wr, u1, u2, ill, wen, stall1, stall2, haz, ov, ir, iss, acc;
    logic [NR-1:0] b, s;
    rd  = int'(m_inst[11:7]);
    rs1 = int'(m_inst[19:15]);
    rs2 = int'(m_inst[24:20]);
    ns  = n_src(m_inst[6:0]);
    wr  = has_rd(m_inst[6:0]);
    u1  = (ns >= 1);
    u2  = (ns == 2);
    ill = (u1 && rs1 >= NR) || (u2 && rs2 >= NR) || (wr && rd >= NR);
    wen = wr && rd != 0 && !ill;
    stall1 = u1 && rs1 != 0 && rs1 < NR && m_busy[rs1 % NR] && fwd_hit(rs1) < 0;
    stall2 = u2 && rs2 != 0 && rs2 < NR && m_busy[rs2 % NR] && fwd_hit(rs2) < 0;
    haz = m_valid && (stall1 || stall2);
    ov  = m_valid && !haz && !flush;
    ir  = !m_valid || (out_ready && !haz && !flush);

    check("out_valid", 32'(out_valid), 32'(ov));
    check("in_ready",  32'(in_ready),  32'(ir));
    check("hazard_o",  32'(hazard_o),  32'(haz));
    check("out_inst",  out_inst, m_inst);
    check("out_pc",    out_pc,   m_pc);
    check("out_spec",  32'(out_spec), 32'(m_spec));
    check("out_rd",    32'(out_rd),   32'(rd % NR));
    check("out_wen",   32'(out_wen),  32'(wen));
    check("out_illegal", 32'(out_illegal), 32'(ill));
    check("rf_raddr1", 32'(rf_raddr1), 32'(rs1 % NR));
    check("busy",      32'(dut.u_scoreboard.busy),      32'(m_busy));
    check("spec_busy", 32'(dut.u_scoreboard.spec_busy), 32'(m_sbusy));
    if (m_valid && !ill && u1) check("out_rs1v", out_rs1v, opnd(rs1));
    if (m_valid && !ill && u2) check("out_rs2v", out_rs2v, opnd(rs2));

    // Advance the model to the state after the coming rising edge.
    iss = ov && out_ready;
    acc = in_valid && ir && !flush;
    if (rst) begin
      m_valid = 1'b0; m_inst = 32'd0; m_pc = 32'd0; m_spec = 1'b0;
      m_busy = '0; m_sbusy = '0;
    end else begin
      b = m_busy;
      s = m_sbusy;
      if (wb_valid) begin
        b[wb_rd] = 1'b0;
        s[wb_rd] = 1'b0;
      end
      if (flush) begin
        b = b & ~s;
        s = '0;
      end else begin
        if (spec_commit) s = '0;
        if (iss && wen) begin
          b[rd % NR] = 1'b1;
          if (m_spec) s[rd % NR] = 1'b1;
        end
      end
      b[0] = 1'b0;
      s[0] = 1'b0;
      m_busy = b;
      m_sbusy = s;
      if (flush)     m_valid = 1'b0;
      else if (acc)  m_valid = 1'b1;
      else if (iss)  m_valid = 1'b0;
      if (acc) begin
        m_inst = in_inst; m_pc = in_pc; m_spec = in_spec;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_pulse(int rd);
    wb_valid = 1'b1;
    wb_rd = RW'(rd);
    nx();
    wb_valid = 1'b0;
  endtask

  task automatic send(logic [31:0] inst, logic [31:0] pc, logic spec);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; in_spec = spec;
    nx();
    in_valid = 1'b0; in_spec = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) rf[i] = 32'h1000_0000 + 32'(i);
    rst = 1'b1; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0; in_spec = 1'b0;
    fwd_valid = '0; fwd_rd = '0; fwd_data = '0;
    wb_valid = 1'b0; wb_rd = '0; spec_commit = 1'b0; flush = 1'b0; out_ready = 1'b1;

    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_hazard",    32'(hazard_o),  32'd0);
    check("rst_out_wen",   32'(out_wen),   32'd0);
    check("rst_out_inst",  out_inst,       32'd0);
    nx();
    rst = 1'b0;

    // Independent stream, one per cycle.
    in_valid = 1'b1; in_inst = enc_i(1, 0, 5); in_pc = 32'h100;
    nx();
    in_inst = enc_i(2, 0, 7); in_pc = 32'h104;
    @(negedge clk);
    check("t1_rd1", 32'(out_rd), 32'd1);
    check("t1_inst_lit", out_inst, 32'h0050_0093);
    nx();
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_rd2", 32'(out_rd), 32'd2);
    check("t1_valid2", 32'(out_valid), 32'd1);
    nx();
    @(negedge clk);
    check("t1_busy", 32'(dut.u_scoreboard.busy), 32'h0006);

    // RAW stall on x1, resolved by channel 1.
    wb_valid = 1'b1; wb_rd = 4'd2;
    send(enc_r(3, 1, 2), 32'h108, 1'b0);
    wb_valid = 1'b0;
    @(negedge clk);
    check("t2_hazard", 32'(hazard_o), 32'd1);
    check("t2_stall_valid", 32'(out_valid), 32'd0);
    nx();
    fwd_valid = 2'b10; fwd_rd = {4'd1, 4'd0}; fwd_data = {32'h55, 32'h0};
    @(negedge clk);
    check("t2_fwd_rs1", out_rs1v, 32'h55);
    check("t2_fwd_valid", 32'(out_valid), 32'd1);
    nx();

    // Both channels match: channel 0 wins.
    fwd_valid = 2'b11; fwd_rd = {4'd4, 4'd4}; fwd_data = {32'hBB, 32'hAA};
    send(enc_r(7, 4, 0), 32'h10C, 1'b0);
    @(negedge clk);
    check("t3_prio", out_rs1v, 32'hAA);
    nx();
    fwd_valid = '0;
    wb_pulse(1); wb_pulse(3); wb_pulse(7);

    // Speculative producer squashed by flush; flush also blocks accept.
    send(enc_u(5), 32'h110, 1'b1);
    @(negedge clk);
    check("t4_spec", 32'(out_spec), 32'd1);
    nx();
    flush = 1'b1; in_valid = 1'b1; in_inst = enc_i(1, 0, 5); in_pc = 32'h200;
    nx();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("t4_busy5", 32'(dut.u_scoreboard.busy), 32'h0000);
    check("t4_sbusy", 32'(dut.u_scoreboard.spec_busy), 32'h0000);
    check("t4_no_accept", 32'(out_valid), 32'd0);

    // Flush suppresses the issue of a held instruction.
    send(enc_u(6), 32'h114, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check("t4_flush_ov", 32'(out_valid), 32'd0);
    nx();
    flush = 1'b0;
    @(negedge clk);
    check("t4_flush_busy", 32'(dut.u_scoreboard.busy), 32'h0000);

    // Commit before flush keeps the producer busy until writeback.
    send(enc_u(5), 32'h118, 1'b1);
    nx();
    spec_commit = 1'b1;
    nx();
    spec_commit = 1'b0; flush = 1'b1;
    nx();
    flush = 1'b0;
    @(negedge clk);
    check("t4_commit_busy", 32'(dut.u_scoreboard.busy), 32'h0020);
    wb_pulse(5);
    @(negedge clk);
    check("t4_wb_busy", 32'(dut.u_scoreboard.busy), 32'h0000);

    // Same-cycle writeback and issue of rd=6: set wins.
    send(enc_u(6), 32'h11C, 1'b0);
    wb_pulse(6);
    @(negedge clk);
    check("t5_set_wins", 32'(dut.u_scoreboard.busy), 32'h0040);
    wb_pulse(6);

    // Illegal rd and store: no write enable, no scoreboard set.
    send(enc_r(17, 1, 2), 32'h120, 1'b0);
    @(negedge clk);
    check("t6_illegal", 32'(out_illegal), 32'd1);
    check("t6_ill_wen", 32'(out_wen), 32'd0);
    nx();
    send(enc_s(2, 1), 32'h124, 1'b0);
    @(negedge clk);
    check("t6_sw_wen", 32'(out_wen), 32'd0);
    nx();
    @(negedge clk);
    check("t6_busy", 32'(dut.u_scoreboard.busy), 32'h0000);

    // Downstream stall keeps the held instruction, then back-to-back RAW.
    out_ready = 1'b0;
    send(enc_i(1, 0, 5), 32'h128, 1'b0);
    in_valid = 1'b1; in_inst = enc_i(2, 0, 7); in_pc = 32'h12C;
    @(negedge clk);
    check("t7_not_ready", 32'(in_ready), 32'd0);
    nx();
    @(negedge clk);
    check("t7_held", out_inst, 32'h0050_0093);
    nx();
    out_ready = 1'b1;
    nx();
    in_inst = enc_r(3, 1, 2); in_pc = 32'h130;
    nx();
    in_valid = 1'b0;
    @(negedge clk);
    check("t7_b2b_hazard", 32'(hazard_o), 32'd1);
    nx();
    wb_pulse(1);
    wb_pulse(2);
    @(negedge clk);
    check("t7_released", 32'(out_valid), 32'd1);
    nx();
    wb_pulse(3);

    // Reset mid-operation.
    send(enc_u(9), 32'h134, 1'b0);
    rst = 1'b1;
    nx();
    rst = 1'b0;
    @(negedge clk);
    check("t8_rst_valid", 32'(out_valid), 32'd0);
    check("t8_rst_busy", 32'(dut.u_scoreboard.busy), 32'h0000);
    nx();
    nx();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_idu_issue.md
# ysyx_idu_issue

Parametrised decode/issue stage that supersedes the single-forward, table-driven IDU. It sits between IFU and EXU. It holds one instruction in a stage register, reads operands with multi-channel forwarding, and tracks in-flight writers in an internal scoreboard instead of an external table. It also squashes speculative state on branch mispredict.

## Interface
- XLEN, 32, datapath width
- NR_REG, 16, architectural registers (16 = RV32E, 32 = RV32I)
- FWD_N, 2, forwarding channels (index 0 = youngest producer, highest priority)
- RIDX_W, $clog2(NR_REG), register index width (derived)

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset; synchronous, active-high
- in_valid / in_ready  in / out  1  upstream handshake
- in_inst  in  32  fetched instruction
- in_pc  in  XLEN  its PC
- in_spec  in  1  instruction fetched under an unresolved prediction
- rf_raddr1 / rf_raddr2  out  RIDX_W  combinational RF read indices = held rs1/rs2
- rf_rdata1 / rf_rdata2  in  XLEN  RF data, same cycle
- fwd_valid  in  FWD_N  forwarding channel valid
- fwd_rd  in  FWD_N*RIDX_W  forwarded destination
- fwd_data  in  FWD_N*XLEN  forwarded value
- wb_valid, wb_rd  in  1, RIDX_W  retirement write; clears busy[wb_rd]
- spec_commit  in  1  prediction resolved correct
- flush  in  1  prediction wrong; squash
- out_valid / out_ready  out / in  1  downstream handshake
- out_inst, out_pc, out_spec  out  32, XLEN, 1  held instruction fields
- out_rs1v, out_rs2v  out  XLEN  resolved operands
- out_rd, out_wen  out  RIDX_W, 1  destination and write-enable
- out_illegal  out  1  a used register field is ≥ NR_REG
- hazard_o  out  1  RAW stall this cycle

## Operation
- Source use by opcode:
  - LUI, AUIPC, JAL: none.
  - JALR, loads, I-ALU, SYSTEM: rs1 only.
  - R, S, B: rs1 and rs2.
- Unused sources never stall.
- out_wen is 0 for S, B and when rd = 0.
- Operand resolution per used source, in priority order:
  - x0 gives 0.
  - Otherwise the lowest-index fwd channel with fwd_valid & fwd_rd == rs.
  - Otherwise rf_rdata.
- Hazard: a used source with busy[rs] = 1 and no matching fwd channel. hazard_o = valid & that condition.
- Scoreboard: busy[NR_REG] and spec_busy[NR_REG]; bit 0 is hard-wired 0.
  - On issue (out fire) with out_wen: set busy[rd]; also set spec_busy[rd] if out_spec.
  - wb_valid clears busy[wb_rd] and spec_busy[wb_rd].
  - Same-cycle set and clear of one register: set wins (newer producer).
- spec_commit clears all spec_busy bits; busy is untouched.
- flush:
  - Clears the valid bit.
  - Clears busy & spec_busy, then clears spec_busy.
  - Suppresses the same-cycle issue and the same-cycle accept.
  - flush takes priority over spec_commit.
- out_illegal: any used field index ≥ NR_REG (bit 4 set when NR_REG = 16). The instruction still issues, with out_wen = 0, so the EXU can trap.

## Timing
- Reset values:
  - Internal: valid = 0, busy = 0, spec_busy = 0.
  - Outputs: out_valid = 0, in_ready = 1, out_inst = 0, out_pc = 0, out_spec = 0, out_wen = 0, hazard_o = 0.
- Latency: an instruction accepted at edge N is visible on out_* in cycle N+1. Operands are combinational from the held fields plus the RF and forwarding inputs.
- out_valid = valid & !hazard & !flush.
- in_ready = !valid | (out_ready & !hazard & !flush).
- Back-to-back accept and issue run at one instruction per cycle.
- Stall: the held instruction and out_* stay stable until issue. The hazard is re-evaluated every cycle as fwd/wb inputs change.
- Issue and accept may occur in the same cycle. Scoreboard updates from an issue are visible to the next held instruction in the following cycle; the back-to-back RAW is caught by busy.
- rst mid-operation drops the held instruction and clears the scoreboard in one cycle.

## Structure
- Opcode constants: reuse `YSYX_OP_*` from ysyx.svh.
- Add a YSYX_SRC_USE encoding (NONE/RS1/RS12) to the shared header.
- Sub-module ysyx_idu_scoreboard (NR_REG):
  - Inputs: set/clear/spec_commit/flush ports.
  - Outputs: busy vector.
- The forwarding mux is a generate loop over FWD_N in the top module.
- Immediate and ALU decode stay in ysyx_idu_decoder, instantiated unchanged.

## Test plan
- Independent stream `addi x1,x0,5`; `addi x2,x0,7` with out_ready = 1 → one issue per cycle, out_rd 1 then 2, busy = 0x0006.
- `add x3,x1,x2` with busy[1] set and no forwarding → hazard_o = 1 and out_valid = 0. Then fwd_valid[1] = 1, fwd_rd = 1, fwd_data = 0x55 → issues with out_rs1v = 0x55.
- Both channels match rd = 4 (ch0 = 0xAA, ch1 = 0xBB) → out_rs1v = 0xAA.
- Issue `lui x5` with in_spec = 1, then flush → busy[5] = 0, spec_busy = 0, out_valid = 0 next cycle. Repeat with spec_commit before the flush → busy[5] stays 1 until wb_rd = 5.
- wb_rd = 6 and issue of rd = 6 in the same cycle → busy[6] = 1.
- NR_REG = 16: `add x17,x1,x2` → out_illegal = 1 and out_wen = 0. `sw x1,0(x2)` → out_wen = 0 and no scoreboard set.
